// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter, video priority with CPU starvation guard
module vram_arbiter #(
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_vid_req,
   input  logic [ADDR_W-1:0] i_vid_addr,
   output logic              o_vid_ack,
   output logic              o_vid_rvalid,
   output logic [DATA_W-1:0] o_vid_rdata,
   input  logic              i_cpu_req,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic              i_cpu_we,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic              o_cpu_rvalid,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]  r_starve_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_mem_wdata;
   // Read tag pipeline: stage1 while the RAM samples the address, stage2 while data returns.
   logic              r_s1_valid;
   logic              r_s1_cpu;
   logic              r_s2_valid;
   logic              r_s2_cpu;

   logic w_force;
   logic w_vid_grant;
   logic w_cpu_grant;

   // A CPU that has waited STARVE_LIMIT cycles pre-empts video for one slot.
   assign w_force     = i_cpu_req && (r_starve_cnt == LIMIT);
   assign w_vid_grant = !i_reset && i_vid_req && !w_force;
   assign w_cpu_grant = !i_reset && i_cpu_req && (w_force || !i_vid_req);

   assign o_vid_ack    = w_vid_grant;
   assign o_cpu_ack    = w_cpu_grant;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_we     = r_mem_we;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_vid_rvalid = r_s2_valid && !r_s2_cpu;
   assign o_cpu_rvalid = r_s2_valid && r_s2_cpu;
   assign o_vid_rdata  = i_mem_rdata;
   assign o_cpu_rdata  = i_mem_rdata;

   // Count consecutive cycles the CPU is left waiting; saturate at the limit.
   always_ff @(posedge i_clock) begin
      if (i_reset || !i_cpu_req || w_cpu_grant) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   // Register the granted access onto the RAM port; idle cycles only drop the write enable.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else if (w_vid_grant) begin
         r_mem_addr <= i_vid_addr;
         r_mem_we   <= 1'b0;
      end else if (w_cpu_grant) begin
         r_mem_addr  <= i_cpu_addr;
         r_mem_we    <= i_cpu_we;
         r_mem_wdata <= i_cpu_wdata;
      end else begin
         r_mem_we <= 1'b0;
      end
   end

   // Track owner of each outstanding read so data returns to the right requester.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_s1_valid <= 1'b0;
         r_s1_cpu   <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_cpu   <= 1'b0;
      end else begin
         r_s1_valid <= w_vid_grant || (w_cpu_grant && !i_cpu_we);
         r_s1_cpu   <= w_cpu_grant;
         r_s2_valid <= r_s1_valid;
         r_s2_cpu   <= r_s1_cpu;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter
module tb_vram_arbiter;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_vid_req = 1'b0;
   logic [10:0] i_vid_addr = '0;
   logic        o_vid_ack, o_vid_rvalid;
   logic [7:0]  o_vid_rdata;
   logic        i_cpu_req = 1'b0;
   logic [10:0] i_cpu_addr = '0;
   logic        i_cpu_we = 1'b0;
   logic [7:0]  i_cpu_wdata = '0;
   logic        o_cpu_ack, o_cpu_rvalid;
   logic [7:0]  o_cpu_rdata;
   logic [10:0] o_mem_addr;
   logic        o_mem_we;
   logic [7:0]  o_mem_wdata;
   logic [7:0]  i_mem_rdata = '0;

   vram_arbiter #(.ADDR_W(11), .DATA_W(8), .STARVE_LIMIT(4)) dut (
      .i_clock(i_clock), .i_reset(i_reset),
      .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr), .o_vid_ack(o_vid_ack),
      .o_vid_rvalid(o_vid_rvalid), .o_vid_rdata(o_vid_rdata),
      .i_cpu_req(i_cpu_req), .i_cpu_addr(i_cpu_addr), .i_cpu_we(i_cpu_we),
      .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(o_cpu_ack),
      .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_rdata(o_cpu_rdata),
      .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clock = ~i_clock;

   int cyc = 0;
   always @(posedge i_clock) cyc <= cyc + 1;

   function automatic logic [7:0] init_val(input logic [10:0] a);
      return a[7:0] * 8'd13 + {5'd0, a[10:8]} + 8'd7;
   endfunction

   // Synchronous RAM attached to the DUT (read-before-write)
   logic [7:0] ram [0:2047];
   logic       ram_wr [0:2047];
   logic       ram_clr = 1'b1;
   always @(posedge i_clock) begin
      if (ram_clr) begin
         for (int i = 0; i < 2048; i++) ram_wr[i] <= 1'b0;
      end else begin
         if (o_mem_we) begin
            ram[o_mem_addr]    <= o_mem_wdata;
            ram_wr[o_mem_addr] <= 1'b1;
         end
         i_mem_rdata <= ram_wr[o_mem_addr] ? ram[o_mem_addr] : init_val(o_mem_addr);
      end
   end

   // Reference memory and scoreboard
   logic [7:0] ref_mem [0:2047];
   logic       ref_wr  [0:2047];
   typedef struct { bit cpu; logic [7:0] data; int due; } sb_item_t;
   sb_item_t sb[$];
   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [7:0] ref_read(input logic [10:0] a);
      return ref_wr[a] ? ref_mem[a] : init_val(a);
   endfunction

   task automatic sb_sample();
      sb_item_t e;
      logic [7:0] rd;
      if (o_vid_rvalid || o_cpu_rvalid) begin
         n_tests++;
         rd = o_cpu_rvalid ? o_cpu_rdata : o_vid_rdata;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected cyc=%0d vid_rvalid=%0b cpu_rvalid=%0b expected no rvalid", cyc, o_vid_rvalid, o_cpu_rvalid);
         end else begin
            e = sb.pop_front();
            if ((o_vid_rvalid && o_cpu_rvalid) || (o_cpu_rvalid !== e.cpu) || (rd !== e.data) || (cyc != e.due)) begin
               n_fail++;
               $display("FAIL sb_read cyc=%0d got cpu=%0b vid=%0b data=%02h, expected cpu=%0b data=%02h at cyc=%0d",
                        cyc, o_cpu_rvalid, o_vid_rvalid, rd, e.cpu, e.data, e.due);
            end
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         n_tests++; n_fail++;
         e = sb.pop_front();
         $display("FAIL sb_missing cyc=%0d got no rvalid, expected cpu=%0b data=%02h", cyc, e.cpu, e.data);
      end
      n_tests++;
      if ((o_vid_ack && o_cpu_ack) || (o_vid_ack && !i_vid_req) || (o_cpu_ack && !i_cpu_req)) begin
         n_fail++;
         $display("FAIL ack_sanity cyc=%0d vid_ack=%0b cpu_ack=%0b, expected at most one ack, only with req", cyc, o_vid_ack, o_cpu_ack);
      end
      if (i_reset) begin
         sb.delete();
      end else begin
         if (i_vid_req && o_vid_ack) sb.push_back('{cpu: 1'b0, data: ref_read(i_vid_addr), due: cyc + 2});
         if (i_cpu_req && o_cpu_ack) begin
            if (i_cpu_we) begin
               ref_mem[i_cpu_addr] = i_cpu_wdata;
               ref_wr[i_cpu_addr]  = 1'b1;
            end else begin
               sb.push_back('{cpu: 1'b1, data: ref_read(i_cpu_addr), due: cyc + 2});
            end
         end
      end
   endtask

   task automatic step();
      sb_sample();
      @(posedge i_clock);
      #1;
   endtask

   task automatic drain(input int n);
      i_vid_req = 1'b0; i_cpu_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge i_clock);
         step();
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_vid_req = 1'b1; i_cpu_req = 1'b1; i_cpu_we = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge i_clock);
         n_tests++;
         if (o_vid_ack !== 1'b0 || o_cpu_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_acks i=%0d vid_ack=%0b cpu_ack=%0b expected 0/0", i, o_vid_ack, o_cpu_ack);
         end
         if (i == 1) begin
            n_tests++;
            if (o_mem_addr !== 11'h0 || o_mem_we !== 1'b0 || o_mem_wdata !== 8'h0 || o_vid_rvalid !== 1'b0 || o_cpu_rvalid !== 1'b0) begin
               n_fail++; $display("FAIL reset_state addr=%03h we=%0b wdata=%02h rv=%0b/%0b expected all 0",
                                  o_mem_addr, o_mem_we, o_mem_wdata, o_vid_rvalid, o_cpu_rvalid);
            end
         end
         step();
      end
      i_reset = 1'b0; i_vid_req = 1'b0; i_cpu_req = 1'b0;
      drain(2);
   endtask

   task automatic test_video();
      for (int i = 0; i < 16; i++) begin
         i_vid_req = 1'b1; i_vid_addr = 11'h010 + 11'(i);
         @(negedge i_clock);
         n_tests++;
         if (o_vid_ack !== 1'b1) begin
            n_fail++; $display("FAIL video_ack i=%0d got=%0b expected 1", i, o_vid_ack);
         end
         step();
      end
      drain(4);
   endtask

   task automatic test_cpu_write_read();
      i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 11'h123; i_cpu_wdata = 8'hA5;
      @(negedge i_clock);
      n_tests++;
      if (o_cpu_ack !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_ack got=%0b expected 1", o_cpu_ack); end
      step();
      i_cpu_we = 1'b0;
      @(negedge i_clock);
      n_tests++;
      if (o_cpu_ack !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 11'h123 || o_mem_wdata !== 8'hA5) begin
         n_fail++; $display("FAIL cpu_wr_issue ack=%0b we=%0b addr=%03h wdata=%02h expected 1/1/123/a5",
                            o_cpu_ack, o_mem_we, o_mem_addr, o_mem_wdata);
      end
      step();
      i_cpu_req = 1'b0;
      @(negedge i_clock);
      n_tests++;
      if (o_mem_we !== 1'b0 || o_mem_addr !== 11'h123 || o_cpu_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL cpu_rd_issue we=%0b addr=%03h rvalid=%0b expected 0/123/0", o_mem_we, o_mem_addr, o_cpu_rvalid);
      end
      step();
      @(negedge i_clock);
      n_tests++;
      if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== 8'hA5) begin
         n_fail++; $display("FAIL cpu_rd_data rvalid=%0b rdata=%02h expected 1/a5", o_cpu_rvalid, o_cpu_rdata);
      end
      step();
      drain(2);
   endtask

   task automatic test_starvation();
      int nv = 0;
      int nc = 0;
      bit exp_cpu;
      i_vid_req = 1'b1; i_cpu_req = 1'b1; i_cpu_we = 1'b0;
      for (int k = 0; k < 20; k++) begin
         i_vid_addr = 11'h200 + 11'(nv);
         i_cpu_addr = 11'h300 + 11'(nc);
         exp_cpu = (k % 5 == 4);
         @(negedge i_clock);
         n_tests++;
         if (o_vid_ack !== !exp_cpu || o_cpu_ack !== exp_cpu) begin
            n_fail++; $display("FAIL starve_pattern k=%0d vid_ack=%0b cpu_ack=%0b expected %0b/%0b", k, o_vid_ack, o_cpu_ack, !exp_cpu, exp_cpu);
         end
         if (o_vid_ack) nv++;
         if (o_cpu_ack) nc++;
         step();
      end
      drain(4);
   endtask

   task automatic test_simultaneous();
      i_vid_req = 1'b1; i_vid_addr = 11'h040; i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 11'h041;
      @(negedge i_clock);
      n_tests++;
      if (o_vid_ack !== 1'b1 || o_cpu_ack !== 1'b0) begin
         n_fail++; $display("FAIL simul_first vid_ack=%0b cpu_ack=%0b expected 1/0", o_vid_ack, o_cpu_ack);
      end
      step();
      i_vid_req = 1'b0;
      @(negedge i_clock);
      n_tests++;
      if (o_cpu_ack !== 1'b1) begin n_fail++; $display("FAIL simul_second cpu_ack=%0b expected 1", o_cpu_ack); end
      step();
      i_cpu_req = 1'b0;
      @(negedge i_clock);
      n_tests++;
      if (o_vid_rvalid !== 1'b1 || o_cpu_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL simul_rv1 vid=%0b cpu=%0b expected 1/0", o_vid_rvalid, o_cpu_rvalid);
      end
      step();
      @(negedge i_clock);
      n_tests++;
      if (o_vid_rvalid !== 1'b0 || o_cpu_rvalid !== 1'b1) begin
         n_fail++; $display("FAIL simul_rv2 vid=%0b cpu=%0b expected 0/1", o_vid_rvalid, o_cpu_rvalid);
      end
      step();
      drain(2);
   endtask

   task automatic test_reset_midop();
      bit exp_cpu;
      i_vid_req = 1'b1; i_vid_addr = 11'h050; i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 11'h060;
      @(negedge i_clock);
      n_tests++;
      if (o_vid_ack !== 1'b1) begin n_fail++; $display("FAIL midrst_accept vid_ack=%0b expected 1", o_vid_ack); end
      step();
      i_reset = 1'b1;
      @(negedge i_clock);
      n_tests++;
      if (o_vid_ack !== 1'b0 || o_cpu_ack !== 1'b0) begin
         n_fail++; $display("FAIL midrst_acks vid_ack=%0b cpu_ack=%0b expected 0/0", o_vid_ack, o_cpu_ack);
      end
      step();
      i_reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         i_vid_addr = 11'h050 + 11'(k);
         exp_cpu = (k == 4);
         @(negedge i_clock);
         if (k == 0) begin
            n_tests++;
            if (o_mem_we !== 1'b0 || o_mem_addr !== 11'h0 || o_mem_wdata !== 8'h0 || o_vid_rvalid !== 1'b0) begin
               n_fail++; $display("FAIL midrst_state we=%0b addr=%03h wdata=%02h vid_rvalid=%0b expected 0/000/00/0",
                                  o_mem_we, o_mem_addr, o_mem_wdata, o_vid_rvalid);
            end
         end
         n_tests++;
         if (o_vid_ack !== !exp_cpu || o_cpu_ack !== exp_cpu) begin
            n_fail++; $display("FAIL midrst_starve k=%0d vid_ack=%0b cpu_ack=%0b expected %0b/%0b", k, o_vid_ack, o_cpu_ack, !exp_cpu, exp_cpu);
         end
         step();
      end
      drain(4);
   endtask

   task automatic test_idle();
      i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 11'h055; i_cpu_wdata = 8'h3C;
      @(negedge i_clock);
      step();
      i_cpu_req = 1'b0; i_cpu_we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clock);
         n_tests++;
         if (o_mem_we !== (i == 0) || o_mem_addr !== 11'h055 || o_mem_wdata !== 8'h3C ||
             o_vid_ack !== 1'b0 || o_cpu_ack !== 1'b0 || o_vid_rvalid !== 1'b0 || o_cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL idle i=%0d we=%0b addr=%03h wdata=%02h acks=%0b%0b rv=%0b%0b expected we=%0b addr=055 wdata=3c rest 0",
                               i, o_mem_we, o_mem_addr, o_mem_wdata, o_vid_ack, o_cpu_ack, o_vid_rvalid, o_cpu_rvalid, (i == 0));
         end
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) ref_wr[i] = 1'b0;
      @(posedge i_clock);
      #1;
      ram_clr = 1'b0;
      test_reset();
      test_video();
      test_cpu_write_read();
      test_starvation();
      test_simultaneous();
      test_reset_midop();
      test_idle();
      drain(3);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover got=%0d outstanding reads expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
